mem_arbiter_2to1: RTL and testbench



---
 rtl/mem_arbiter_2to1_pkg.sv | 23 ++
 rtl/mem_arbiter_2to1_if.sv | 27 ++
 rtl/mem_arbiter_2to1_rr_pick2.sv | 26 ++
 rtl/mem_arbiter_2to1.sv | 120 ++++++++++++
 tb/tb_mem_arbiter_2to1.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_2to1_pkg.sv
// Shared definitions for the I/D-cache to main-memory block arbiter.
package mem_if_pkg;

   localparam int unsigned ADDR_W = 28;
   localparam int unsigned DATA_W = 128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_t;

   // The client that did not win last time.
   function automatic grant_t other_grant(input grant_t g);
      return (g == GNT_I) ? GNT_D : GNT_I;
   endfunction

endpackage

// File: rtl/mem_arbiter_2to1_if.sv
// Block-memory request/response bundle. The requester (cache, or the arbiter
// facing memory) uses master; the responder uses slave.
interface mem_arbiter_2to1_if
   import mem_if_pkg::*;
#(
   parameter int unsigned ADDR_W = mem_if_pkg::ADDR_W,
   parameter int unsigned DATA_W = mem_if_pkg::DATA_W
);

   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;

   modport master (
      output read, write, addr, wdata,
      input  rdata, ready
   );

   modport slave (
      input  read, write, addr, wdata,
      output rdata, ready
   );

endinterface

// File: rtl/mem_arbiter_2to1_rr_pick2.sv
// Two-way request selector: round-robin against last_grant, or fixed
// priority to the D-cache when PRIO_MODE is 1.
module rr_pick2
   import mem_if_pkg::*;
#(
   parameter int unsigned PRIO_MODE = 0
) (
   input  logic   req_i,
   input  logic   req_d,
   input  grant_t last_grant,
   output grant_t grant,
   output logic   valid
);

   // Pick a winner whenever at least one client requests.
   always_comb begin
      valid = req_i | req_d;
      grant = GNT_I;
      if (req_i && req_d) begin
         grant = (PRIO_MODE == 1) ? GNT_D : other_grant(last_grant);
      end else if (req_d) begin
         grant = GNT_D;
      end
   end

endmodule

// File: rtl/mem_arbiter_2to1.sv
// Arbitrates the I-cache and D-cache block ports onto one main-memory port.
// One transaction at a time; a DRAIN cycle after each completion hides the
// granted cache's stale request.
module mem_arbiter_2to1
   import mem_if_pkg::*;
#(
   parameter int unsigned ADDR_W    = mem_if_pkg::ADDR_W,
   parameter int unsigned DATA_W    = mem_if_pkg::DATA_W,
   parameter int unsigned PRIO_MODE = 0
) (
   input  logic              clk,
   input  logic              proc_reset_n,
   mem_arbiter_2to1_if.slave  i_port,
   mem_arbiter_2to1_if.slave  d_port,
   mem_arbiter_2to1_if.master mem_port
);

   arb_state_t        state_q,     state_d;
   grant_t            last_grant_q, last_grant_d;
   logic              mem_read_q,  mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic   req_i;
   logic   req_d;
   grant_t pick_grant;
   logic   pick_valid;
   logic   sel_i;
   logic   sel_d;

   assign req_i = i_port.read | i_port.write;
   assign req_d = d_port.read | d_port.write;

   rr_pick2 #(
      .PRIO_MODE (PRIO_MODE)
   ) u_pick (
      .req_i      (req_i),
      .req_d      (req_d),
      .last_grant (last_grant_q),
      .grant      (pick_grant),
      .valid      (pick_valid)
   );

   // State and registered memory-side request.
   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         state_q      <= IDLE;
         last_grant_q <= GNT_I;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   // Next state: capture the winner in IDLE, release memory on completion.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d      = BUSY;
               last_grant_d = pick_grant;
               // A client asserting read and write together is treated as a write.
               if (pick_grant == GNT_D) begin
                  mem_write_d = d_port.write;
                  mem_read_d  = d_port.read & ~d_port.write;
                  mem_addr_d  = d_port.addr;
                  mem_wdata_d = d_port.wdata;
               end else begin
                  mem_write_d = i_port.write;
                  mem_read_d  = i_port.read & ~i_port.write;
                  mem_addr_d  = i_port.addr;
                  mem_wdata_d = i_port.wdata;
               end
            end
         end
         BUSY: begin
            if (mem_port.ready) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               state_d     = DRAIN;
            end
         end
         DRAIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign sel_i = (state_q == BUSY) && (last_grant_q == GNT_I);
   assign sel_d = (state_q == BUSY) && (last_grant_q == GNT_D);

   assign mem_port.read  = mem_read_q;
   assign mem_port.write = mem_write_q;
   assign mem_port.addr  = mem_addr_q;
   assign mem_port.wdata = mem_wdata_q;

   assign i_port.ready = sel_i & mem_port.ready;
   assign i_port.rdata = sel_i ? mem_port.rdata : '0;
   assign d_port.ready = sel_d & mem_port.ready;
   assign d_port.rdata = sel_d ? mem_port.rdata : '0;

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Directed bench for mem_arbiter_2to1: round-robin instance (dut) and
// fixed-priority instance (dut_p) sharing clock and reset.
module tb_mem_arbiter_2to1;
   import mem_if_pkg::*;

   localparam logic [127:0] PAT_A5 = {16{8'hA5}};
   localparam logic [127:0] PAT_D1 = 128'hD1D1_0000_0000_0000_0000_0000_0000_00D1;
   localparam logic [127:0] PAT_I1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

   logic clk;
   logic proc_reset_n;
   int   tests;
   int   fails;

   mem_arbiter_2to1_if i_bus  ();
   mem_arbiter_2to1_if d_bus  ();
   mem_arbiter_2to1_if m_bus  ();
   mem_arbiter_2to1_if ip_bus ();
   mem_arbiter_2to1_if dp_bus ();
   mem_arbiter_2to1_if mp_bus ();

   mem_arbiter_2to1 #(.ADDR_W(28), .DATA_W(128), .PRIO_MODE(0)) dut (
      .clk          (clk),
      .proc_reset_n (proc_reset_n),
      .i_port       (i_bus.slave),
      .d_port       (d_bus.slave),
      .mem_port     (m_bus.master)
   );

   mem_arbiter_2to1 #(.ADDR_W(28), .DATA_W(128), .PRIO_MODE(1)) dut_p (
      .clk          (clk),
      .proc_reset_n (proc_reset_n),
      .i_port       (ip_bus.slave),
      .d_port       (dp_bus.slave),
      .mem_port     (mp_bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      tests++;
      if ({m_bus.read, m_bus.write, i_bus.ready, d_bus.ready} !== 4'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b want 0000", {m_bus.read, m_bus.write, i_bus.ready, d_bus.ready});
      end
      tests++;
      if (m_bus.addr !== 28'h0 || m_bus.wdata !== 128'h0) begin
         fails++;
         $display("FAIL reset_addr_wdata: got %h/%h want 0/0", m_bus.addr, m_bus.wdata);
      end
      tests++;
      if (i_bus.rdata !== 128'h0 || d_bus.rdata !== 128'h0) begin
         fails++;
         $display("FAIL reset_rdata: got %h/%h want 0/0", i_bus.rdata, d_bus.rdata);
      end
      proc_reset_n = 1'b1;
      // Start an I read, then pull reset in the middle of the BUSY phase.
      @(negedge clk);
      i_bus.read = 1'b1;
      i_bus.addr = 28'h0000005;
      @(negedge clk);
      tests++;
      if (m_bus.read !== 1'b1 || m_bus.addr !== 28'h0000005) begin
         fails++;
         $display("FAIL rst_busy_req: got read=%b addr=%h want 1/0000005", m_bus.read, m_bus.addr);
      end
      m_bus.ready = 1'b1;
      m_bus.rdata = PAT_A5;
      #1;
      tests++;
      if (i_bus.ready !== 1'b1) begin
         fails++;
         $display("FAIL rst_busy_pre_ready: got %b want 1", i_bus.ready);
      end
      #1 proc_reset_n = 1'b0;
      #1;
      tests++;
      if ({m_bus.read, i_bus.ready, d_bus.ready} !== 3'b000 || m_bus.addr !== 28'h0) begin
         fails++;
         $display("FAIL rst_async: got read/iready/dready=%b addr=%h want 000/0",
                  {m_bus.read, i_bus.ready, d_bus.ready}, m_bus.addr);
      end
      tests++;
      if (i_bus.rdata !== 128'h0) begin
         fails++;
         $display("FAIL rst_async_rdata: got %h want 0", i_bus.rdata);
      end
      i_bus.read  = 1'b0;
      i_bus.addr  = '0;
      m_bus.ready = 1'b0;
      m_bus.rdata = '0;
      @(negedge clk);
      proc_reset_n = 1'b1;
      @(negedge clk);
      tests++;
      if (dut.state_q !== IDLE || m_bus.read !== 1'b0) begin
         fails++;
         $display("FAIL rst_release_idle: got state=%0d read=%b want 0/0", dut.state_q, m_bus.read);
      end
   endtask

   task automatic test_lone_i_read();
      i_bus.read = 1'b1;
      i_bus.addr = 28'h0000010;
      @(negedge clk);
      tests++;
      if (m_bus.read !== 1'b1 || m_bus.write !== 1'b0 || m_bus.addr !== 28'h0000010) begin
         fails++;
         $display("FAIL lone_req: got r=%b w=%b addr=%h want 1/0/0000010", m_bus.read, m_bus.write, m_bus.addr);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests++;
         if (m_bus.read !== 1'b1 || i_bus.ready !== 1'b0 || m_bus.addr !== 28'h0000010) begin
            fails++;
            $display("FAIL lone_hold: cyc %0d got r=%b ready=%b addr=%h want 1/0/0000010",
                     k, m_bus.read, i_bus.ready, m_bus.addr);
         end
      end
      @(negedge clk);
      m_bus.ready = 1'b1;
      m_bus.rdata = PAT_A5;
      #1;
      tests++;
      if (i_bus.ready !== 1'b1 || i_bus.rdata !== PAT_A5) begin
         fails++;
         $display("FAIL lone_resp: got ready=%b rdata=%h want 1/%h", i_bus.ready, i_bus.rdata, PAT_A5);
      end
      tests++;
      if (d_bus.ready !== 1'b0 || d_bus.rdata !== 128'h0) begin
         fails++;
         $display("FAIL lone_d_quiet: got ready=%b rdata=%h want 0/0", d_bus.ready, d_bus.rdata);
      end
      @(negedge clk);
      m_bus.ready = 1'b0;
      m_bus.rdata = '0;
      tests++;
      if (m_bus.read !== 1'b0 || i_bus.ready !== 1'b0) begin
         fails++;
         $display("FAIL lone_drain: got read=%b ready=%b want 0/0", m_bus.read, i_bus.ready);
      end
      @(negedge clk);
      i_bus.read = 1'b0;
      tests++;
      if (m_bus.read !== 1'b0) begin
         fails++;
         $display("FAIL lone_stale_ignored: got read=%b want 0", m_bus.read);
      end
   endtask

   // Both request with last_grant = I: D must go first, then I.
   task automatic test_round_robin();
      d_bus.read = 1'b1;
      d_bus.addr = 28'h0000020;
      i_bus.read = 1'b1;
      i_bus.addr = 28'h0000030;
      @(negedge clk);
      tests++;
      if (m_bus.read !== 1'b1 || m_bus.addr !== 28'h0000020) begin
         fails++;
         $display("FAIL rr_first: got read=%b addr=%h want 1/0000020", m_bus.read, m_bus.addr);
      end
      m_bus.ready = 1'b1;
      m_bus.rdata = PAT_D1;
      #1;
      tests++;
      if (d_bus.ready !== 1'b1 || d_bus.rdata !== PAT_D1 || i_bus.ready !== 1'b0 || i_bus.rdata !== 128'h0) begin
         fails++;
         $display("FAIL rr_first_resp: got d=%b/%h i=%b/%h want 1/%h 0/0",
                  d_bus.ready, d_bus.rdata, i_bus.ready, i_bus.rdata, PAT_D1);
      end
      @(negedge clk);
      m_bus.ready = 1'b0;
      m_bus.rdata = '0;
      tests++;
      if (m_bus.read !== 1'b0 || d_bus.ready !== 1'b0) begin
         fails++;
         $display("FAIL rr_drain: got read=%b dready=%b want 0/0", m_bus.read, d_bus.ready);
      end
      @(negedge clk);
      d_bus.read = 1'b0;
      tests++;
      if (m_bus.read !== 1'b0) begin
         fails++;
         $display("FAIL rr_idle_gap: got read=%b want 0", m_bus.read);
      end
      @(negedge clk);
      tests++;
      if (m_bus.read !== 1'b1 || m_bus.addr !== 28'h0000030) begin
         fails++;
         $display("FAIL rr_second: got read=%b addr=%h want 1/0000030", m_bus.read, m_bus.addr);
      end
      m_bus.ready = 1'b1;
      m_bus.rdata = PAT_I1;
      #1;
      tests++;
      if (i_bus.ready !== 1'b1 || i_bus.rdata !== PAT_I1 || d_bus.ready !== 1'b0) begin
         fails++;
         $display("FAIL rr_second_resp: got i=%b/%h dready=%b want 1/%h 0",
                  i_bus.ready, i_bus.rdata, d_bus.ready, PAT_I1);
      end
      @(negedge clk);
      m_bus.ready = 1'b0;
      m_bus.rdata = '0;
      @(negedge clk);
      i_bus.read = 1'b0;
   endtask

   // D write-back then allocate, with an I read pending; last_grant becomes D.
   task automatic test_back_to_back();
      d_bus.write = 1'b1;
      d_bus.addr  = 28'h0000040;
      d_bus.wdata = 128'h1234;
      @(negedge clk);
      tests++;
      if (m_bus.write !== 1'b1 || m_bus.read !== 1'b0 || m_bus.addr !== 28'h0000040 || m_bus.wdata !== 128'h1234) begin
         fails++;
         $display("FAIL wb_req: got w=%b r=%b addr=%h wdata=%h want 1/0/0000040/1234",
                  m_bus.write, m_bus.read, m_bus.addr, m_bus.wdata);
      end
      i_bus.read = 1'b1;
      i_bus.addr = 28'h0000050;
      @(negedge clk);
      tests++;
      if (m_bus.write !== 1'b1 || m_bus.addr !== 28'h0000040 || m_bus.wdata !== 128'h1234) begin
         fails++;
         $display("FAIL wb_hold: got w=%b addr=%h wdata=%h want 1/0000040/1234", m_bus.write, m_bus.addr, m_bus.wdata);
      end
      m_bus.ready = 1'b1;
      #1;
      tests++;
      if (d_bus.ready !== 1'b1 || i_bus.ready !== 1'b0) begin
         fails++;
         $display("FAIL wb_resp: got dready=%b iready=%b want 1/0", d_bus.ready, i_bus.ready);
      end
      @(negedge clk);
      m_bus.ready = 1'b0;
      tests++;
      if (m_bus.write !== 1'b0 || m_bus.read !== 1'b0) begin
         fails++;
         $display("FAIL wb_no_dup: got w=%b r=%b want 0/0", m_bus.write, m_bus.read);
      end
      @(negedge clk);
      d_bus.write = 1'b0;
      d_bus.read  = 1'b1;
      d_bus.addr  = 28'h0000080;
      tests++;
      if (m_bus.write !== 1'b0 || m_bus.read !== 1'b0) begin
         fails++;
         $display("FAIL wb_idle: got w=%b r=%b want 0/0", m_bus.write, m_bus.read);
      end
      @(negedge clk);
      tests++;
      if (m_bus.read !== 1'b1 || m_bus.write !== 1'b0 || m_bus.addr !== 28'h0000050) begin
         fails++;
         $display("FAIL alloc_rr_i_first: got r=%b w=%b addr=%h want 1/0/0000050", m_bus.read, m_bus.write, m_bus.addr);
      end
      m_bus.ready = 1'b1;
      m_bus.rdata = PAT_I1;
      #1;
      tests++;
      if (i_bus.ready !== 1'b1 || i_bus.rdata !== PAT_I1 || d_bus.ready !== 1'b0) begin
         fails++;
         $display("FAIL alloc_i_resp: got i=%b/%h dready=%b want 1/%h 0", i_bus.ready, i_bus.rdata, d_bus.ready, PAT_I1);
      end
      @(negedge clk);
      m_bus.ready = 1'b0;
      m_bus.rdata = '0;
      @(negedge clk);
      i_bus.read = 1'b0;
      @(negedge clk);
      tests++;
      if (m_bus.read !== 1'b1 || m_bus.addr !== 28'h0000080) begin
         fails++;
         $display("FAIL alloc_d: got read=%b addr=%h want 1/0000080", m_bus.read, m_bus.addr);
      end
      m_bus.ready = 1'b1;
      m_bus.rdata = PAT_D1;
      #1;
      tests++;
      if (d_bus.ready !== 1'b1 || d_bus.rdata !== PAT_D1) begin
         fails++;
         $display("FAIL alloc_d_resp: got %b/%h want 1/%h", d_bus.ready, d_bus.rdata, PAT_D1);
      end
      @(negedge clk);
      m_bus.ready = 1'b0;
      m_bus.rdata = '0;
      @(negedge clk);
      d_bus.read = 1'b0;
   endtask

   // Fixed priority: D wins three times in a row while I keeps asking.
   task automatic test_fixed_prio();
      ip_bus.read = 1'b1;
      ip_bus.addr = 28'h0000100;
      dp_bus.read = 1'b1;
      dp_bus.addr = 28'h0000200;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         tests++;
         if (mp_bus.read !== 1'b1 || mp_bus.addr !== 28'h0000200) begin
            fails++;
            $display("FAIL prio_grant: txn %0d got read=%b addr=%h want 1/0000200", t, mp_bus.read, mp_bus.addr);
         end
         mp_bus.ready = 1'b1;
         mp_bus.rdata = PAT_D1;
         #1;
         tests++;
         if (dp_bus.ready !== 1'b1 || ip_bus.ready !== 1'b0) begin
            fails++;
            $display("FAIL prio_resp: txn %0d got dready=%b iready=%b want 1/0", t, dp_bus.ready, ip_bus.ready);
         end
         @(negedge clk);
         mp_bus.ready = 1'b0;
         mp_bus.rdata = '0;
         @(negedge clk);
      end
      ip_bus.read = 1'b0;
      dp_bus.read = 1'b0;
      @(negedge clk);
      mp_bus.ready = 1'b1;
      @(negedge clk);
      mp_bus.ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_spurious_ready();
      m_bus.ready = 1'b1;
      m_bus.rdata = PAT_A5;
      #1;
      tests++;
      if (i_bus.ready !== 1'b0 || d_bus.ready !== 1'b0 || i_bus.rdata !== 128'h0 || d_bus.rdata !== 128'h0) begin
         fails++;
         $display("FAIL spur_fwd: got i=%b/%h d=%b/%h want 0/0 0/0",
                  i_bus.ready, i_bus.rdata, d_bus.ready, d_bus.rdata);
      end
      @(negedge clk);
      m_bus.ready = 1'b0;
      m_bus.rdata = '0;
      tests++;
      if (dut.state_q !== IDLE || m_bus.read !== 1'b0 || m_bus.write !== 1'b0) begin
         fails++;
         $display("FAIL spur_state: got state=%0d r=%b w=%b want 0/0/0", dut.state_q, m_bus.read, m_bus.write);
      end
   endtask

   task automatic test_read_write_both();
      i_bus.read  = 1'b1;
      i_bus.write = 1'b1;
      i_bus.addr  = 28'h0000060;
      i_bus.wdata = 128'h55;
      @(negedge clk);
      tests++;
      if (m_bus.write !== 1'b1 || m_bus.read !== 1'b0 || m_bus.wdata !== 128'h55 || m_bus.addr !== 28'h0000060) begin
         fails++;
         $display("FAIL rw_write_wins: got w=%b r=%b wdata=%h addr=%h want 1/0/55/0000060",
                  m_bus.write, m_bus.read, m_bus.wdata, m_bus.addr);
      end
      m_bus.ready = 1'b1;
      @(negedge clk);
      m_bus.ready = 1'b0;
      @(negedge clk);
      i_bus.read  = 1'b0;
      i_bus.write = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      tests        = 0;
      fails        = 0;
      proc_reset_n = 1'b0;
      i_bus.read  = 1'b0; i_bus.write  = 1'b0; i_bus.addr  = '0; i_bus.wdata  = '0;
      d_bus.read  = 1'b0; d_bus.write  = 1'b0; d_bus.addr  = '0; d_bus.wdata  = '0;
      ip_bus.read = 1'b0; ip_bus.write = 1'b0; ip_bus.addr = '0; ip_bus.wdata = '0;
      dp_bus.read = 1'b0; dp_bus.write = 1'b0; dp_bus.addr = '0; dp_bus.wdata = '0;
      m_bus.ready  = 1'b0; m_bus.rdata  = '0;
      mp_bus.ready = 1'b0; mp_bus.rdata = '0;

      test_reset();
      test_lone_i_read();
      test_round_robin();
      test_back_to_back();
      test_fixed_prio();
      test_spurious_ready();
      test_read_write_both();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
